// File: rtl/mul_pkg.sv
// Shared types and defaults for the shared signed multiplier arbiter.
package mul_pkg;

  localparam int N_DEF       = 4;
  localparam int W_DEF       = 3;
  localparam int MUL_LAT_DEF = 4;

  // Tag ids are sized for the largest supported requester count so one tag type serves every N.
  localparam int N_MAX = 8;
  localparam int ID_W  = $clog2(N_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  function automatic tag_t make_tag(input logic valid, input logic [ID_W-1:0] id);
    tag_t t;
    t.valid = valid;
    t.id    = valid ? id : '0;
    return t;
  endfunction

endpackage

// File: rtl/mul_tag_pipe.sv
// Depth-D shift register of in-flight tags; reset invalidates every stage.
module mul_tag_pipe
  import mul_pkg::*;
#(
  parameter int D = MUL_LAT_DEF + 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stages [D];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < D; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_out = stages[D-1];

endmodule

// File: rtl/mul_share_arb.sv
// Shares one pipelined signed multiplier between N requesters and routes products back by tag.
// MUL_ARB_RR_EN selects round-robin arbitration; without it the lowest requester index wins.
module mul_share_arb
  import mul_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int W       = W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             drain,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     rsp_valid,
  output logic [2*W-1:0]   rsp_p,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  output logic             mul_en,
  input  logic [2*W-1:0]   mul_p,
  output logic             idle
);

  localparam int D     = MUL_LAT + 1;
  localparam int CNT_W = $clog2(D + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t           state_q;
  state_t           state_d;
  logic             issue_ok;
  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] scan_idx;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic             handshake;
  logic [CNT_W-1:0] inflight_q;
  tag_t             tag_in;
  tag_t             tag_exit;

`ifdef MUL_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W:0]   scan_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Issuing is only allowed in RUN with drain low, so a same-cycle drain always wins.
  always_comb begin
    state_d  = state_q;
    mul_en   = 1'b0;
    idle     = 1'b0;
    issue_ok = 1'b0;
    case (state_q)
      IDLE: begin
        idle = 1'b1;
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        mul_en = 1'b1;
        if (drain) begin
          state_d = DRAIN;
        end else begin
          issue_ok = 1'b1;
        end
      end
      DRAIN: begin
        mul_en = 1'b1;
        if (inflight_q == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
`ifdef MUL_ARB_RR_EN
    scan_sum  = '0;
`endif
    for (int k = 0; k < N; k++) begin
`ifdef MUL_ARB_RR_EN
      scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan_sum >= (IDX_W+1)'(N)) begin
        scan_sum = scan_sum - (IDX_W+1)'(N);
      end
      scan_idx = scan_sum[IDX_W-1:0];
`else
      scan_idx = IDX_W'(k);
`endif
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        sel_a = req_a[k*W +: W];
        sel_b = req_b[k*W +: W];
      end
    end
  end

  assign req_ready = (issue_ok && grant_any) ? (N'(1) << grant_idx) : '0;
  assign handshake = |(req_valid & req_ready);

`ifdef MUL_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (handshake) begin
      rr_ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end
`endif

  // Operands hold between issues; the multiplier never stalls so stale values are harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (handshake) begin
      mul_a <= sel_a;
      mul_b <= sel_b;
    end
  end

  assign tag_in = make_tag(handshake, ID_W'(grant_idx));

  mul_tag_pipe #(
    .D (D)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_exit)
  );

  // The tag leaves the pipe exactly when its product is present on mul_p.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_p     <= '0;
    end else begin
      rsp_valid <= '0;
      if (tag_exit.valid) begin
        rsp_valid <= N'(1) << tag_exit.id;
        rsp_p     <= mul_p;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      case ({handshake, tag_exit.valid})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboard bench for mul_share_arb driving a behavioural pipelined signed multiplier.
module tb_mul_share_arb;

  localparam int N       = 4;
  localparam int W       = 3;
  localparam int MUL_LAT = 4;
  localparam int PW      = 2 * W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             drain;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     rsp_valid;
  logic [PW-1:0]    rsp_p;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic             mul_en;
  logic [PW-1:0]    mul_p;
  logic             idle;

  typedef struct {
    logic [N-1:0]  owner;
    logic [PW-1:0] prod;
    int            due;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic signed [PW-1:0] mul_pipe [MUL_LAT];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: product appears MUL_LAT posedges after the operands change.
  initial begin
    for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] = '0;
  end

  always @(posedge clk) begin
    mul_pipe[0] <= $signed(mul_a) * $signed(mul_b);
    for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end

  assign mul_p = mul_pipe[MUL_LAT-1];

  mul_share_arb #(
    .N       (N),
    .W       (W),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .drain     (drain),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_p     (rsp_p),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_en    (mul_en),
    .mul_p     (mul_p),
    .idle      (idle)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input int v0, input int v1, input int v2, input int v3);
    logic [N*W-1:0] r;
    r[0*W +: W] = W'(v0);
    r[1*W +: W] = W'(v1);
    r[2*W +: W] = W'(v2);
    r[3*W +: W] = W'(v3);
    return r;
  endfunction

  // One cycle of stimulus: drive at negedge, check the combinational grant, queue the response.
  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                               input logic st, input logic dr, input logic [N-1:0] exp_ready,
                               input logic [PW-1:0] exp_prod, input logic track, input string name);
    exp_t e;
    @(negedge clk);
    req_valid = valid;
    req_a     = a;
    req_b     = b;
    start     = st;
    drain     = dr;
    #1;
    checkOutput(name, 32'(req_ready), 32'(exp_ready));
    if (track && exp_ready != '0) begin
      e.owner = exp_ready;
      e.prod  = exp_prod;
      e.due   = cyc + MUL_LAT + 2;
      sb_q.push_back(e);
    end
  endtask

  // Monitor: every response must match the head of the scoreboard, on the expected cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_valid !== '0) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("rsp_owner", 32'(rsp_valid), 32'(e.owner));
        checkOutput("rsp_p", 32'(rsp_p), 32'(e.prod));
        checkOutput("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      e = sb_q.pop_front();
      checkOutput("rsp_timeout", 32'd0, 32'(e.owner));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0]   sel_ready;
    logic [PW-1:0]  sel_prod;
    int             owner_idx;
    logic [N*W-1:0] zero_ops;

    zero_ops  = '0;
    rst       = 1'b1;
    start     = 1'b0;
    drain     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_idle", 32'(idle), 32'd1);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_p", 32'(rsp_p), 32'd0);
    checkOutput("reset_mul_a", 32'(mul_a), 32'd0);
    checkOutput("reset_mul_b", 32'(mul_b), 32'd0);
    checkOutput("reset_mul_en", 32'(mul_en), 32'd0);
    rst = 1'b0;

    $display("[TB] drain and requests while idle are ignored");
    applyStimulus(4'b1111, pack(1, 1, 1, 1), pack(1, 1, 1, 1), 1'b0, 1'b1, 4'b0000, '0, 1'b1, "ready_idle_drain");
    applyStimulus(4'b1111, pack(1, 1, 1, 1), pack(1, 1, 1, 1), 1'b0, 1'b0, 4'b0000, '0, 1'b1, "ready_idle_valid");
    checkOutput("idle_still_idle", 32'(idle), 32'd1);

    $display("[TB] single issue from requester 2");
    applyStimulus(4'b0000, zero_ops, zero_ops, 1'b1, 1'b0, 4'b0000, '0, 1'b1, "ready_start");
    applyStimulus(4'b0100, pack(0, 0, -3, 0), pack(0, 0, 2, 0), 1'b0, 1'b0, 4'b0100, PW'(-6), 1'b1, "ready_single");
    checkOutput("idle_in_run", 32'(idle), 32'd0);
    checkOutput("mul_en_in_run", 32'(mul_en), 32'd1);
    applyStimulus(4'b0000, zero_ops, zero_ops, 1'b1, 1'b0, 4'b0000, '0, 1'b1, "ready_start_in_run");
    checkOutput("mul_a_issue", 32'(mul_a), 32'(3'b101));
    checkOutput("mul_b_issue", 32'(mul_b), 32'(3'b010));
    applyStimulus(4'b0000, zero_ops, zero_ops, 1'b0, 1'b0, 4'b0000, '0, 1'b1, "ready_gap");
    checkOutput("mul_a_hold", 32'(mul_a), 32'(3'b101));
    checkOutput("idle_after_start_in_run", 32'(idle), 32'd0);
    repeat (4) applyStimulus(4'b0000, zero_ops, zero_ops, 1'b0, 1'b0, 4'b0000, '0, 1'b1, "ready_wait");

    $display("[TB] all requesters valid every cycle");
    for (int k = 0; k < 8; k++) begin
`ifdef MUL_ARB_RR_EN
      owner_idx = (3 + k) % N;
`else
      owner_idx = 0;
`endif
      applyStimulus(4'b1111, pack(1, 2, 3, 4), pack(-1, -1, -1, -1), 1'b0, 1'b0,
                    N'(1) << owner_idx, PW'(-(owner_idx + 1)), 1'b1, "ready_all_valid");
    end

`ifdef MUL_ARB_RR_EN
    sel_ready = 4'b1000;
    sel_prod  = PW'(-6);
`else
    sel_ready = 4'b0010;
    sel_prod  = PW'(6);
`endif
    applyStimulus(4'b1010, pack(0, 2, 0, -2), pack(0, 3, 0, 3), 1'b0, 1'b0, sel_ready, sel_prod, 1'b1, "ready_sparse");

    $display("[TB] operand extremes");
    applyStimulus(4'b0001, pack(-4, 0, 0, 0), pack(-4, 0, 0, 0), 1'b0, 1'b0, 4'b0001, PW'(16), 1'b1, "ready_ext_neg");
    applyStimulus(4'b0010, pack(0, 3, 0, 0), pack(0, -4, 0, 0), 1'b0, 1'b0, 4'b0010, PW'(-12), 1'b1, "ready_ext_mix");

    $display("[TB] three issues then drain");
    applyStimulus(4'b0001, pack(1, 0, 0, 0), pack(1, 0, 0, 0), 1'b0, 1'b0, 4'b0001, PW'(1), 1'b1, "ready_b2b_0");
    applyStimulus(4'b0010, pack(0, 2, 0, 0), pack(0, 2, 0, 0), 1'b0, 1'b0, 4'b0010, PW'(4), 1'b1, "ready_b2b_1");
    applyStimulus(4'b0100, pack(0, 0, -1, 0), pack(0, 0, 3, 0), 1'b0, 1'b0, 4'b0100, PW'(-3), 1'b1, "ready_b2b_2");
    applyStimulus(4'b1111, pack(1, 1, 1, 1), pack(1, 1, 1, 1), 1'b0, 1'b1, 4'b0000, '0, 1'b1, "ready_drain_wins");
    checkOutput("idle_drain_cycle", 32'(idle), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(4'b1111, pack(1, 1, 1, 1), pack(1, 1, 1, 1), 1'b0, 1'b0, 4'b0000, '0, 1'b1, "ready_in_drain");
      checkOutput("idle_drain_seq", 32'(idle), (k >= 6) ? 32'd1 : 32'd0);
    end
    checkOutput("mul_en_back_idle", 32'(mul_en), 32'd0);

    $display("[TB] reset with an operation in flight");
    applyStimulus(4'b0000, zero_ops, zero_ops, 1'b1, 1'b0, 4'b0000, '0, 1'b1, "ready_start2");
    applyStimulus(4'b0001, pack(1, 0, 0, 0), pack(2, 0, 0, 0), 1'b0, 1'b0, 4'b0001, PW'(2), 1'b0, "ready_pre_reset");
    applyStimulus(4'b0000, zero_ops, zero_ops, 1'b0, 1'b0, 4'b0000, '0, 1'b1, "ready_post_issue");
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    #1;
    checkOutput("rst_mid_mul_a", 32'(mul_a), 32'd0);
    checkOutput("rst_mid_mul_b", 32'(mul_b), 32'd0);
    checkOutput("rst_mid_idle", 32'(idle), 32'd1);
    checkOutput("rst_mid_mul_en", 32'(mul_en), 32'd0);
    checkOutput("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_mid_rsp_p", 32'(rsp_p), 32'd0);
    checkOutput("rst_mid_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    repeat (8) applyStimulus(4'b0000, zero_ops, zero_ops, 1'b0, 1'b0, 4'b0000, '0, 1'b1, "ready_after_reset");

    $display("[TB] restart after reset");
    applyStimulus(4'b0000, zero_ops, zero_ops, 1'b1, 1'b0, 4'b0000, '0, 1'b1, "ready_start3");
    applyStimulus(4'b1111, pack(-2, 1, 1, 1), pack(3, 1, 1, 1), 1'b0, 1'b0, 4'b0001, PW'(-6), 1'b1, "ready_ptr_reset");
    applyStimulus(4'b0000, zero_ops, zero_ops, 1'b0, 1'b1, 4'b0000, '0, 1'b1, "ready_final_drain");

    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("final_idle", 32'(idle), 32'd1);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
